// File: rtl/store_align_unit_pkg.sv
// Shared store-type and FSM encodings for the store alignment path.
// Includes the base lane-mask helper used by the lane shifter.
package store_align_unit_pkg;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } store_type_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_e;

    // Unshifted byte-enable pattern for a store of the given size.
    function automatic logic [7:0] base_mask(input logic [1:0] store_type);
        logic [7:0] m;
        case (store_type)
            ST_SB:   m = 8'b0000_0001;
            ST_SH:   m = 8'b0000_0011;
            ST_SW:   m = 8'b0000_1111;
            default: m = 8'b0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_align_unit_lane_shifter.sv
// Combinational lane placement: an 8-lane byte mask and 64-bit data image of a store
// shifted by its byte offset; the upper half belongs to the next word.
module store_lane_shifter
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  store_type,
    input  logic [1:0]  k,
    input  logic [31:0] store_data,
    output logic [7:0]  lane_mask,
    output logic [63:0] lane_data
);

    logic [31:0] payload;

    always_comb begin
        payload = 32'd0;
        case (store_type)
            ST_SB:   payload = {24'd0, store_data[7:0]};
            ST_SH:   payload = {16'd0, store_data[15:0]};
            ST_SW:   payload = store_data;
            default: payload = 32'd0;
        endcase
    end

    assign lane_mask = base_mask(store_type) << k;
    assign lane_data = {32'd0, payload} << {k, 3'b000};

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: byte-addressed SB/SH/SW into word-addressed masked writes.
// MISALIGN_SPLIT_EN: defined = split word-crossing stores in two writes; undefined = fault them.
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        StoreTypeM,
    input  logic [ADDR_W-1:0] AddrM,
    input  logic [31:0]       StoreDataM,
    output logic              StallM,
    output logic [3:0]        MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWD,
    output logic              MisalignFault
);

    logic [7:0]        lane_mask;
    logic [63:0]       lane_data;
    logic              split_req;
    logic [ADDR_W-1:0] word_addr;

    logic [3:0]        mem_we_d,   mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [31:0]       mem_wd_d,   mem_wd_q;
    logic              fault_d,    fault_q;

    store_lane_shifter u_shifter (
        .store_type (StoreTypeM),
        .k          (AddrM[1:0]),
        .store_data (StoreDataM),
        .lane_mask  (lane_mask),
        .lane_data  (lane_data)
    );

    assign split_req = |lane_mask[7:4];
    assign word_addr = {AddrM[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_SPLIT_EN
    state_e            state_d,    state_q;
    logic [3:0]        sec_we_d,   sec_we_q;
    logic [ADDR_W-1:0] sec_addr_d, sec_addr_q;
    logic [31:0]       sec_wd_d,   sec_wd_q;
    logic [ADDR_W-1:0] next_word_addr;

    // Wraps naturally at the top of the address space.
    assign next_word_addr = word_addr + ADDR_W'(4);

    always_comb begin
        state_d    = state_q;
        sec_we_d   = sec_we_q;
        sec_addr_d = sec_addr_q;
        sec_wd_d   = sec_wd_q;
        mem_we_d   = 4'b0000;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        fault_d    = 1'b0;
        StallM     = 1'b0;
        case (state_q)
            S_SPLIT: begin
                // The re-presented store on the inputs is ignored here.
                mem_we_d   = sec_we_q;
                mem_addr_d = sec_addr_q;
                mem_wd_d   = sec_wd_q;
                state_d    = S_IDLE;
            end
            default: begin
                if (StoreTypeM != ST_NONE) begin
                    mem_we_d   = lane_mask[3:0];
                    mem_addr_d = word_addr;
                    mem_wd_d   = lane_data[31:0];
                    if (split_req) begin
                        StallM     = 1'b1;
                        sec_we_d   = lane_mask[7:4];
                        sec_addr_d = next_word_addr;
                        sec_wd_d   = lane_data[63:32];
                        state_d    = S_SPLIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sec_we_q   <= 4'b0000;
            sec_addr_q <= '0;
            sec_wd_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            sec_we_q   <= sec_we_d;
            sec_addr_q <= sec_addr_d;
            sec_wd_q   <= sec_wd_d;
        end
    end
`else
    logic unused_upper;

    // Only the first word is ever written, so the carry-over bytes are dropped.
    assign unused_upper = ^lane_data[63:32];
    assign StallM       = 1'b0;

    always_comb begin
        mem_we_d   = 4'b0000;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        fault_d    = 1'b0;
        if (StoreTypeM != ST_NONE) begin
            if (split_req) begin
                fault_d = 1'b1;
            end else begin
                mem_we_d   = lane_mask[3:0];
                mem_addr_d = word_addr;
                mem_wd_d   = lane_data[31:0];
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_q   <= 4'b0000;
            mem_addr_q <= '0;
            mem_wd_q   <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            fault_q    <= fault_d;
        end
    end

    assign MemWE         = mem_we_q;
    assign MemAddr       = mem_addr_q;
    assign MemWD         = mem_wd_q;
    assign MisalignFault = fault_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: vector table for single-write stores plus
// hand-written split / fault / reset sequences.
module tb_store_align_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  StoreTypeM;
    logic [31:0] AddrM;
    logic [31:0] StoreDataM;
    logic        StallM;
    logic [3:0]  MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWD;
    logic        MisalignFault;

    int checks;
    int errors;

    store_align_unit #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .StoreTypeM    (StoreTypeM),
        .AddrM         (AddrM),
        .StoreDataM    (StoreDataM),
        .StallM        (StallM),
        .MemWE         (MemWE),
        .MemAddr       (MemAddr),
        .MemWD         (MemWD),
        .MisalignFault (MisalignFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        logic [31:0] maddr;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
        StoreTypeM = st;
        AddrM      = a;
        StoreDataM = d;
        #1;
    endtask

    task automatic chk_write(input string name, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        chk({name, ".we"},   {60'd0, MemWE}, {60'd0, we});
        chk({name, ".addr"}, {32'd0, MemAddr}, {32'd0, a});
        chk({name, ".wd"},   {32'd0, MemWD}, {32'd0, d});
        $display("txn %s: we=%b addr=%08h wd=%08h fault=%b", name, MemWE, MemAddr, MemWD, MisalignFault);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        StoreTypeM = 2'd0;
        AddrM = 32'd0;
        StoreDataM = 32'd0;

        //                st     addr          data          we       maddr         wd
        vecs[0] = '{2'd1, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'h0000_1000, 32'hA500_0000};
        vecs[1] = '{2'd2, 32'h0000_2001, 32'hFFFF_1234, 4'b0110, 32'h0000_2000, 32'h0012_3400};
        vecs[2] = '{2'd3, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 32'h0000_4000, 32'hCAFE_F00D};
        vecs[3] = '{2'd1, 32'h0000_5000, 32'h1234_56FF, 4'b0001, 32'h0000_5000, 32'h0000_00FF};
        vecs[4] = '{2'd2, 32'h0000_6002, 32'h0000_BEEF, 4'b1100, 32'h0000_6000, 32'hBEEF_0000};
        vecs[5] = '{2'd0, 32'h0000_7000, 32'h9999_9999, 4'b0000, 32'h0000_6000, 32'hBEEF_0000};
        vecs[6] = '{2'd1, 32'h0000_8001, 32'h0000_0077, 4'b0010, 32'h0000_8000, 32'h0000_7700};
        vecs[7] = '{2'd2, 32'h0000_9000, 32'hAAAA_5555, 4'b0011, 32'h0000_9000, 32'h0000_5555};
        vecs[8] = '{2'd1, 32'h0000_A002, 32'h0000_003C, 4'b0100, 32'h0000_A000, 32'h003C_0000};

        step();
        step();
        chk("rst.stall", {63'd0, StallM}, 64'd0);
        chk_write("rst", 4'b0000, 32'd0, 32'd0);
        chk("rst.fault", {63'd0, MisalignFault}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].st, vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d.stall", i), {63'd0, StallM}, 64'd0);
            step();
            chk_write($sformatf("vec%0d", i), vecs[i].we, vecs[i].maddr, vecs[i].wd);
            chk($sformatf("vec%0d.fault", i), {63'd0, MisalignFault}, 64'd0);
        end
        drive(2'd0, 32'd0, 32'd0);
        step();
        chk("idle.we", {60'd0, MemWE}, 64'd0);

`ifdef MISALIGN_SPLIT_EN
        // SW across a word boundary, then a back-to-back aligned SW.
        drive(2'd3, 32'h0000_3002, 32'hDEAD_BEEF);
        chk("sw_split.stall1", {63'd0, StallM}, 64'd1);
        step();
        chk_write("sw_split.w1", 4'b1100, 32'h0000_3000, 32'hBEEF_0000);
        chk("sw_split.stall2", {63'd0, StallM}, 64'd0);
        step();
        chk_write("sw_split.w2", 4'b0011, 32'h0000_3004, 32'h0000_DEAD);
        drive(2'd3, 32'h0000_3008, 32'h1122_3344);
        chk("sw_next.stall", {63'd0, StallM}, 64'd0);
        step();
        chk_write("sw_next", 4'b1111, 32'h0000_3008, 32'h1122_3344);
        chk("sw_next.fault", {63'd0, MisalignFault}, 64'd0);
        drive(2'd0, 32'd0, 32'd0);
        step();
        chk("sw_next.drop", {60'd0, MemWE}, 64'd0);

        // SH at the last byte of the address space wraps to word 0.
        drive(2'd2, 32'hFFFF_FFFF, 32'h0000_ABCD);
        chk("sh_wrap.stall", {63'd0, StallM}, 64'd1);
        step();
        chk_write("sh_wrap.w1", 4'b1000, 32'hFFFF_FFFC, 32'hCD00_0000);
        step();
        chk_write("sh_wrap.w2", 4'b0001, 32'h0000_0000, 32'h0000_00AB);
        drive(2'd0, 32'd0, 32'd0);
        step();
        chk("sh_wrap.drop", {60'd0, MemWE}, 64'd0);

        // Reset in the middle of a split discards the second half.
        drive(2'd3, 32'h0000_5001, 32'h0102_0304);
        step();
        chk_write("rst_mid.w1", 4'b1110, 32'h0000_5000, 32'h0203_0400);
        rst = 1'b1;
        drive(2'd0, 32'd0, 32'd0);
        chk_write("rst_mid.async", 4'b0000, 32'd0, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid.stall", {63'd0, StallM}, 64'd0);
        step();
        chk_write("rst_mid.post1", 4'b0000, 32'd0, 32'd0);
        step();
        chk_write("rst_mid.post2", 4'b0000, 32'd0, 32'd0);
        drive(2'd3, 32'h0000_0003, 32'h0000_0000);
        chk("rst_mid.idle_stall", {63'd0, StallM}, 64'd1);
        drive(2'd0, 32'd0, 32'd0);
`else
        // Word-crossing SW is rejected with a one-cycle fault and no write.
        drive(2'd3, 32'h0000_3002, 32'hDEAD_BEEF);
        chk("sw_fault.stall", {63'd0, StallM}, 64'd0);
        step();
        chk("sw_fault.we", {60'd0, MemWE}, 64'd0);
        chk("sw_fault.fault", {63'd0, MisalignFault}, 64'd1);
        $display("txn sw_fault: we=%b fault=%b", MemWE, MisalignFault);
        drive(2'd3, 32'h0000_3008, 32'h1122_3344);
        step();
        chk_write("sw_next", 4'b1111, 32'h0000_3008, 32'h1122_3344);
        chk("sw_next.fault", {63'd0, MisalignFault}, 64'd0);

        drive(2'd2, 32'hFFFF_FFFF, 32'h0000_ABCD);
        chk("sh_fault.stall", {63'd0, StallM}, 64'd0);
        step();
        chk("sh_fault.we", {60'd0, MemWE}, 64'd0);
        chk("sh_fault.fault", {63'd0, MisalignFault}, 64'd1);
        $display("txn sh_fault: we=%b fault=%b", MemWE, MisalignFault);
        drive(2'd0, 32'd0, 32'd0);
        step();
        chk("sh_fault.clear", {63'd0, MisalignFault}, 64'd0);

        // Asynchronous reset clears the output registers immediately.
        rst = 1'b1;
        #1;
        chk_write("rst_async", 4'b0000, 32'd0, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_async.fault", {63'd0, MisalignFault}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
